// File: rtl/friscv_mem_arbiter_if.sv
// rtl/friscv_mem_arbiter_if.sv - fetch/data requester and shared memory port bundle
interface friscv_mem_arbiter_if #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
);
  logic              inst_en;
  logic [ADDRW-1:0]  inst_addr;
  logic [XLEN-1:0]   inst_rdata;
  logic              inst_ready;
  logic              inst_err;

  logic              data_en;
  logic              data_wr;
  logic [ADDRW-1:0]  data_addr;
  logic [XLEN-1:0]   data_wdata;
  logic [XLEN/8-1:0] data_strb;
  logic [XLEN-1:0]   data_rdata;
  logic              data_ready;
  logic              data_err;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDRW-1:0]  mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_strb;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  modport slave (
    input  inst_en, inst_addr,
    input  data_en, data_wr, data_addr, data_wdata, data_strb,
    input  mem_rdata, mem_ready,
    output inst_rdata, inst_ready, inst_err,
    output data_rdata, data_ready, data_err,
    output mem_en, mem_wr, mem_addr, mem_wdata, mem_strb
  );

  modport master (
    output inst_en, inst_addr,
    output data_en, data_wr, data_addr, data_wdata, data_strb,
    output mem_rdata, mem_ready,
    input  inst_rdata, inst_ready, inst_err,
    input  data_rdata, data_ready, data_err,
    input  mem_en, mem_wr, mem_addr, mem_wdata, mem_strb
  );
endinterface

// File: rtl/friscv_mem_arbiter.sv
// rtl/friscv_mem_arbiter.sv - round-robin fetch/data arbiter onto one memory port
module friscv_mem_arbiter #(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  friscv_mem_arbiter_if.slave  bus
);
  localparam int SW  = XLEN / 8;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t           state_q, state_d;
  logic             last_d_q, last_d_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_wr_q, mem_wr_d;
  logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]    mem_strb_q, mem_strb_d;
  logic [XLEN-1:0]  inst_rdata_q, inst_rdata_d;
  logic             inst_ready_q, inst_ready_d;
  logic             inst_err_q, inst_err_d;
  logic [XLEN-1:0]  data_rdata_q, data_rdata_d;
  logic             data_ready_q, data_ready_d;
  logic             data_err_q, data_err_d;
  logic             wd_expired;

  assign wd_expired = WD_EN && (wdog_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    wdog_d       = wdog_q;
    mem_en_d     = mem_en_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_strb_d   = mem_strb_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ready_d = 1'b0;
    inst_err_d   = 1'b0;
    data_ready_d = 1'b0;
    data_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is granted.
        if (bus.inst_en && (!bus.data_en || last_d_q)) begin
          state_d     = BUSY_I;
          last_d_d    = 1'b0;
          wdog_d      = '0;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = bus.inst_addr;
          mem_wdata_d = '0;
          mem_strb_d  = '0;
        end else if (bus.data_en) begin
          state_d     = BUSY_D;
          last_d_d    = 1'b1;
          wdog_d      = '0;
          mem_en_d    = 1'b1;
          mem_wr_d    = bus.data_wr;
          mem_addr_d  = bus.data_addr;
          mem_wdata_d = bus.data_wdata;
          mem_strb_d  = bus.data_strb;
        end
      end
      BUSY_I, BUSY_D: begin
        // A late mem_ready on the last watchdog cycle still completes normally.
        if (bus.mem_ready || wd_expired) begin
          mem_en_d = 1'b0;
          if (state_q == BUSY_I) begin
            state_d      = RESP_I;
            inst_ready_d = 1'b1;
            inst_err_d   = !bus.mem_ready;
            inst_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            state_d      = RESP_D;
            data_ready_d = 1'b1;
            data_err_d   = !bus.mem_ready;
            data_rdata_d = (bus.mem_ready && !mem_wr_q) ? bus.mem_rdata : '0;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_d_q     <= 1'b1;
      wdog_q       <= '0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_strb_q   <= '0;
      inst_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      inst_err_q   <= 1'b0;
      data_rdata_q <= '0;
      data_ready_q <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      wdog_q       <= wdog_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_strb_q   <= mem_strb_d;
      inst_rdata_q <= inst_rdata_d;
      inst_ready_q <= inst_ready_d;
      inst_err_q   <= inst_err_d;
      data_rdata_q <= data_rdata_d;
      data_ready_q <= data_ready_d;
      data_err_q   <= data_err_d;
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_strb   = mem_strb_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.inst_ready = inst_ready_q;
  assign bus.inst_err   = inst_err_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.data_ready = data_ready_q;
  assign bus.data_err   = data_err_q;
endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// tb/tb_friscv_mem_arbiter.sv - directed and randomized checks of the memory arbiter
module tb_friscv_mem_arbiter;
  localparam int ADDRW = 16;
  localparam int XLEN  = 32;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_en, data_en, data_wr, mem_ready;
  logic [15:0] inst_addr, data_addr;
  logic [31:0] data_wdata, mem_rdata;
  logic [3:0]  data_strb;

  always #5 aclk = ~aclk;

  friscv_mem_arbiter_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus_a ();
  friscv_mem_arbiter_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus_s ();

  assign bus_a.inst_en = inst_en;       assign bus_s.inst_en = inst_en;
  assign bus_a.inst_addr = inst_addr;   assign bus_s.inst_addr = inst_addr;
  assign bus_a.data_en = data_en;       assign bus_s.data_en = data_en;
  assign bus_a.data_wr = data_wr;       assign bus_s.data_wr = data_wr;
  assign bus_a.data_addr = data_addr;   assign bus_s.data_addr = data_addr;
  assign bus_a.data_wdata = data_wdata; assign bus_s.data_wdata = data_wdata;
  assign bus_a.data_strb = data_strb;   assign bus_s.data_strb = data_strb;
  assign bus_a.mem_rdata = mem_rdata;   assign bus_s.mem_rdata = mem_rdata;
  assign bus_a.mem_ready = mem_ready;   assign bus_s.mem_ready = mem_ready;

  friscv_mem_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN), .TIMEOUT(4)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_a)
  );
  friscv_mem_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN), .TIMEOUT(64)) dut_s (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_s)
  );

  int checks = 0;
  int failures = 0;

  // Random-phase reference state: requesters, current access, expected responses.
  logic [31:0] mem_m [16];
  int          busy, stall;
  bit          pend_i, pend_d, hold_i, hold_d, in_resp_i, in_resp_d, resp_next;
  bit          exp_err, last_d, samp_i, samp_d, was_idle, exp_issue, cur_d, cur_wr;
  logic [15:0] cur_addr;
  logic [31:0] cur_wd, exp_rd, last_ri, last_rd;
  logic [3:0]  cur_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic en, input logic wr,
                         input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] st);
    chk({tag, ".mem_en"}, {31'd0, bus_a.mem_en}, {31'd0, en});
    chk({tag, ".mem_wr"}, {31'd0, bus_a.mem_wr}, {31'd0, wr});
    chk({tag, ".mem_addr"}, {16'd0, bus_a.mem_addr}, {16'd0, addr});
    chk({tag, ".mem_wdata"}, bus_a.mem_wdata, wd);
    chk({tag, ".mem_strb"}, {28'd0, bus_a.mem_strb}, {28'd0, st});
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_en = 0; inst_addr = 0; data_en = 0; data_wr = 0; data_addr = 0;
    data_wdata = 0; data_strb = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 0;
    tick();
    tick();
    aresetn = 1;
  endtask

  initial begin
    idle_inputs();
    aresetn = 0;
    tick();
    tick();
    chk("rst.mem_en", bus_a.mem_en, 0);
    chk("rst.mem_addr", bus_a.mem_addr, 0);
    chk("rst.mem_strb", bus_a.mem_strb, 0);
    chk("rst.inst_ready", bus_a.inst_ready, 0);
    chk("rst.data_ready", bus_a.data_ready, 0);
    chk("rst.inst_rdata", bus_a.inst_rdata, 0);
    chk("rst.data_rdata", bus_a.data_rdata, 0);
    aresetn = 1;

    // Single fetch with immediate memory response.
    inst_en = 1; inst_addr = 16'h0010;
    tick();
    chk_mem("fetch.c1", 1, 0, 16'h0010, 0, 0);
    chk("fetch.c1.inst_ready", bus_a.inst_ready, 0);
    mem_ready = 1; mem_rdata = 32'h00500093;
    tick();
    chk("fetch.c2.mem_en", bus_a.mem_en, 0);
    chk("fetch.c2.inst_ready", bus_a.inst_ready, 1);
    chk("fetch.c2.inst_rdata", bus_a.inst_rdata, 32'h00500093);
    chk("fetch.c2.inst_err", bus_a.inst_err, 0);
    mem_ready = 0;
    tick();
    inst_en = 0;
    chk("fetch.c3.inst_ready", bus_a.inst_ready, 0);
    chk("fetch.c3.mem_en", bus_a.mem_en, 0);
    tick();
    chk("fetch.c4.mem_en", bus_a.mem_en, 0);

    // Contention from reset: inst first, then alternate.
    do_reset();
    inst_en = 1; inst_addr = 16'h0020;
    data_en = 1; data_wr = 1; data_addr = 16'h0100; data_wdata = 32'hDEADBEEF; data_strb = 4'hF;
    tick();
    chk_mem("cont.inst1", 1, 0, 16'h0020, 0, 0);
    mem_ready = 1; mem_rdata = 32'h11111111;
    tick();
    chk("cont.inst1.inst_ready", bus_a.inst_ready, 1);
    chk("cont.inst1.data_ready", bus_a.data_ready, 0);
    chk("cont.inst1.inst_rdata", bus_a.inst_rdata, 32'h11111111);
    mem_ready = 0;
    tick();
    chk("cont.idle.mem_en", bus_a.mem_en, 0);
    tick();
    chk_mem("cont.data1", 1, 1, 16'h0100, 32'hDEADBEEF, 4'hF);
    mem_ready = 1; mem_rdata = 32'h22222222;
    tick();
    chk("cont.data1.data_ready", bus_a.data_ready, 1);
    chk("cont.data1.data_rdata", bus_a.data_rdata, 0);
    chk("cont.data1.inst_ready", bus_a.inst_ready, 0);
    mem_ready = 0;
    tick();
    tick();
    chk_mem("cont.inst2", 1, 0, 16'h0020, 0, 0);
    mem_ready = 1; mem_rdata = 32'h33333333;
    tick();
    chk("cont.inst2.inst_rdata", bus_a.inst_rdata, 32'h33333333);
    mem_ready = 0;
    tick();
    tick();
    chk_mem("cont.data2", 1, 1, 16'h0100, 32'hDEADBEEF, 4'hF);

    // Five-cycle stall on the long-timeout instance.
    do_reset();
    data_en = 1; data_wr = 0; data_addr = 16'h0080; data_strb = 4'hF;
    tick();
    for (int c = 1; c <= 5; c++) begin
      chk("stall.mem_en", bus_s.mem_en, 1);
      chk("stall.mem_addr", bus_s.mem_addr, 16'h0080);
      chk("stall.data_ready", bus_s.data_ready, 0);
      if (c == 5) begin mem_ready = 1; mem_rdata = 32'h12345678; end
      tick();
    end
    chk("stall.resp.data_ready", bus_s.data_ready, 1);
    chk("stall.resp.data_rdata", bus_s.data_rdata, 32'h12345678);
    chk("stall.resp.mem_en", bus_s.mem_en, 0);
    mem_ready = 0;
    tick();
    chk("stall.nodup.data_ready", bus_s.data_ready, 0);
    chk("stall.nodup.mem_en", bus_s.mem_en, 0);
    data_en = 0;
    tick();
    chk("stall.after.mem_en", bus_s.mem_en, 0);

    // mem_ready on the final watchdog cycle, then a full timeout.
    do_reset();
    data_en = 1; data_wr = 0; data_addr = 16'h0044; data_strb = 4'h3;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("wdlast.mem_en", bus_a.mem_en, 1);
      if (c == 4) begin mem_ready = 1; mem_rdata = 32'hA5A50F0F; end
      tick();
    end
    chk("wdlast.data_ready", bus_a.data_ready, 1);
    chk("wdlast.data_err", bus_a.data_err, 0);
    chk("wdlast.data_rdata", bus_a.data_rdata, 32'hA5A50F0F);
    mem_ready = 0;
    tick();
    data_addr = 16'h0048;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("wd.mem_en", bus_a.mem_en, 1);
      chk("wd.mem_addr", bus_a.mem_addr, 16'h0048);
      chk("wd.data_ready", bus_a.data_ready, 0);
      tick();
    end
    chk("wd.resp.mem_en", bus_a.mem_en, 0);
    chk("wd.resp.data_ready", bus_a.data_ready, 1);
    chk("wd.resp.data_err", bus_a.data_err, 1);
    chk("wd.resp.data_rdata", bus_a.data_rdata, 0);
    tick();
    data_en = 0; inst_en = 1; inst_addr = 16'h0050;
    chk("wd.after.data_err", bus_a.data_err, 0);
    tick();
    chk_mem("wd.next", 1, 0, 16'h0050, 0, 0);
    mem_ready = 1; mem_rdata = 32'h00000013;
    tick();
    chk("wd.next.inst_ready", bus_a.inst_ready, 1);
    chk("wd.next.inst_err", bus_a.inst_err, 0);
    chk("wd.next.inst_rdata", bus_a.inst_rdata, 32'h00000013);
    mem_ready = 0;

    // Reset while a data access is in flight.
    do_reset();
    data_en = 1; data_wr = 0; data_addr = 16'h0200; data_strb = 4'hF;
    tick();
    chk("rstmid.busy.mem_en", bus_a.mem_en, 1);
    aresetn = 0; inst_en = 1; inst_addr = 16'h0030;
    tick();
    chk("rstmid.mem_en", bus_a.mem_en, 0);
    chk("rstmid.data_ready", bus_a.data_ready, 0);
    aresetn = 1;
    tick();
    chk_mem("rstmid.inst", 1, 0, 16'h0030, 0, 0);
    chk("rstmid.inst.data_ready", bus_a.data_ready, 0);

    // Randomized traffic against a transaction-level reference.
    do_reset();
    foreach (mem_m[k]) mem_m[k] = $urandom();
    busy = -1; stall = 0; last_d = 1;
    pend_i = 0; pend_d = 0; hold_i = 0; hold_d = 0;
    in_resp_i = 0; in_resp_d = 0; resp_next = 0; exp_err = 0;
    last_ri = 0; last_rd = 0; exp_rd = 0;
    cur_d = 0; cur_wr = 0; cur_addr = 0; cur_wd = 0; cur_st = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold_i) hold_i = 0;
      else if (!pend_i) begin
        inst_en = 1'($urandom_range(0, 1));
        if (inst_en) begin pend_i = 1; inst_addr = 16'($urandom_range(0, 15)); end
      end
      if (hold_d) hold_d = 0;
      else if (!pend_d) begin
        data_en = 1'($urandom_range(0, 1));
        if (data_en) begin
          pend_d = 1;
          data_wr = 1'($urandom_range(0, 1));
          data_addr = 16'($urandom_range(0, 15));
          data_wdata = $urandom();
          data_strb = 4'($urandom_range(1, 15));
        end
      end
      mem_rdata = $urandom();
      mem_ready = 0;
      if (busy >= 0) begin
        if (busy == 0) stall = $urandom_range(0, 5);
        if (busy == stall) begin
          mem_ready = 1;
          exp_err = 0;
          resp_next = 1;
          if (cur_wr) begin
            for (int b = 0; b < 4; b++)
              if (cur_st[b]) mem_m[cur_addr[3:0]][8*b +: 8] = cur_wd[8*b +: 8];
            exp_rd = 0;
          end else begin
            mem_rdata = mem_m[cur_addr[3:0]];
            exp_rd = mem_rdata;
          end
        end else if (busy == 3) begin
          exp_err = 1;
          exp_rd = 0;
          resp_next = 1;
        end
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
      end
      samp_i = inst_en;
      samp_d = data_en;
      was_idle = (busy < 0) && !in_resp_i && !in_resp_d;
      tick();

      in_resp_i = resp_next && !cur_d;
      in_resp_d = resp_next && cur_d;
      if (resp_next) busy = -1;
      else if (busy >= 0) busy++;
      resp_next = 0;
      if (in_resp_i) begin last_ri = exp_rd; pend_i = 0; hold_i = 1; end
      if (in_resp_d) begin last_rd = exp_rd; pend_d = 0; hold_d = 1; end
      chk("rnd.inst_ready", bus_a.inst_ready, in_resp_i);
      chk("rnd.data_ready", bus_a.data_ready, in_resp_d);
      chk("rnd.inst_err", bus_a.inst_err, in_resp_i && exp_err);
      chk("rnd.data_err", bus_a.data_err, in_resp_d && exp_err);
      chk("rnd.inst_rdata", bus_a.inst_rdata, last_ri);
      chk("rnd.data_rdata", bus_a.data_rdata, last_rd);
      if (busy >= 0) begin
        chk_mem("rnd.busy", 1, cur_wr, cur_addr, cur_wd, cur_st);
      end else begin
        exp_issue = was_idle && (samp_i || samp_d);
        chk("rnd.issue", bus_a.mem_en, exp_issue);
        if (exp_issue) begin
          cur_d = samp_d && (!samp_i || !last_d);
          last_d = cur_d;
          cur_wr   = cur_d ? data_wr : 1'b0;
          cur_addr = cur_d ? data_addr : inst_addr;
          cur_wd   = cur_d ? data_wdata : 32'd0;
          cur_st   = cur_d ? data_strb : 4'd0;
          busy = 0;
          chk_mem("rnd.grant", 1, cur_wr, cur_addr, cur_wd, cur_st);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/friscv_mem_arbiter.md
Name: friscv_mem_arbiter

Overview:
- Shares one physical memory port between the control unit's instruction-fetch interface and the processing unit's data (memfy) interface.
- Sits between the rv32i core top level and a single unified instruction/data memory.
- Arbitration is round-robin, one outstanding transaction at a time.
- A watchdog aborts transactions the memory never acknowledges.

Parameters:
- ADDRW, 16, address width of both requester ports and the memory port.
- XLEN, 32, data width; strobe width is XLEN/8.
- TIMEOUT, 64, cycles to wait for mem_ready before aborting; 0 disables the watchdog.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- inst_en  in  1  fetch request, held until inst_ready
- inst_addr  in  ADDRW  fetch address, stable while inst_en
- inst_rdata  out  XLEN  fetched word, valid with inst_ready
- inst_ready  out  1  one-cycle completion pulse for fetch
- inst_err  out  1  with inst_ready: fetch aborted by watchdog
- data_en  in  1  data request, held until data_ready
- data_wr  in  1  1=write, 0=read
- data_addr  in  ADDRW  data address
- data_wdata  in  XLEN  write data
- data_strb  in  XLEN/8  byte strobes
- data_rdata  out  XLEN  read data, valid with data_ready
- data_ready  out  1  one-cycle completion pulse for data
- data_err  out  1  with data_ready: aborted by watchdog
- mem_en  out  1  shared memory request
- mem_wr  out  1  shared write flag
- mem_addr  out  ADDRW  shared address
- mem_wdata  out  XLEN  shared write data
- mem_strb  out  XLEN/8  shared strobes
- mem_rdata  in  XLEN  memory read data, valid when mem_ready
- mem_ready  in  1  memory completion

Behaviour:
- Reset (aresetn=0 at a rising edge): all outputs 0, FSM=IDLE, last-grant pointer=DATA (so inst wins the first tie), watchdog=0.
- Reset mid-transaction: the in-flight access is dropped with no ready pulse; mem_en=0 on the next cycle.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - Sample inst_en/data_en.
  - If only one is high, grant it.
  - If both are high, grant the one not granted last, then update the pointer.
  - On grant, register addr/wr/wdata/strb into the mem_* outputs and go to BUSY_x.
  - For inst, mem_wr=0, mem_strb=0, mem_wdata=0.
- BUSY_x:
  - mem_en=1; mem_* outputs stay stable.
  - On mem_ready=1: capture mem_rdata (data writes capture 0), drop mem_en next cycle, go to RESP_x.
- RESP_x: assert x_ready=1 for exactly one cycle with the registered rdata; x_err=0; go to IDLE.
- Latency: request seen in cycle 0 -> mem_en in cycle 1 -> earliest mem_ready in cycle 1 -> x_ready in cycle 2. Throughput is at most one access per 3 cycles.
- Requester rules:
  - Requesters hold en and payload stable until their ready.
  - They may re-assert en (new request) in the cycle after ready.
  - IDLE never samples a requester during its RESP cycle, so a held en is never double-issued.
- Watchdog:
  - Counter clears on entering BUSY_x and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT-1 with no mem_ready: mem_en drops, go to RESP_x, x_ready=1 with x_err=1 and rdata=0.
  - mem_ready arriving in that same cycle wins: normal completion, no error.
- Non-granted outputs: x_rdata holds its last value; x_ready=0 and x_err=0 except in RESP_x.
- Spurious mem_ready outside BUSY is ignored.
- data_en dropped mid-BUSY: the access still completes and the ready pulse is still issued.

Test Plan:
- Single fetch: inst_en=1, inst_addr=0x0010; memory answers mem_ready in cycle 1 with 0x00500093 -> mem_en=1 and mem_addr=0x0010 only in cycle 1; inst_ready=1 with inst_rdata=0x00500093 in cycle 2.
- Contention: inst_en and data_en (write 0xDEADBEEF, strb=0xF, addr 0x0100) both high from reset -> inst granted first; data write issued next with mem_wr=1; then continued contention alternates inst/data.
- Data read with 5-cycle memory stall -> mem_en and mem_addr stable for all 5 cycles; data_ready pulses once, 1 cycle after mem_ready; no duplicate issue while data_en is still held in the RESP cycle.
- Watchdog, TIMEOUT=4, memory never ready -> mem_en high 4 cycles then low; data_ready=1, data_err=1, data_rdata=0; the next request proceeds normally.
- mem_ready on the final watchdog cycle -> normal completion with captured data, err=0.
- aresetn=0 during BUSY_D -> next cycle mem_en=0, no data_ready, FSM IDLE; a subsequent inst fetch is granted first.
